hdlc_command_rx: RTL



---
 rtl/hdlc_command_rx.sv | 86 ++++++++
 1 files changed

// File: rtl/hdlc_command_rx.sv
// hdlc_command_rx: hunts the 422 command line for the sync word, then deserialises a 32-bit command.
// Optional HDLC_CMD_RX_DEGLITCH_EN: 2-of-3 majority filter on the synchronised line.
module hdlc_command_rx #(
  parameter logic [15:0] SYNC_WORD    = 16'h55AA,
  parameter logic [1:0]  SAMPLE_PHASE = 2'd3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  clk_cnt,
  input  logic        rx_en,
  input  logic        data_in,
  output logic [31:0] cmd_data,
  output logic        cmd_valid,
  output logic        busy,
  output logic [7:0]  frame_cnt
);
  typedef enum logic {HUNT, RECV} state_t;
  state_t state, state_n;
  logic s1, s2, rx_bit, sample;
  logic [15:0] sync_sr, sync_n, sync_shift;
  logic [31:0] data_sr, data_n, cmd_n, word;
  logic [4:0] bit_cnt, cnt_n;
  logic [7:0] frame_n;
  logic valid_n;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) {s1, s2} <= 2'b00;
    else {s1, s2} <= {data_in, s1};
`ifdef HDLC_CMD_RX_DEGLITCH_EN
  logic [1:0] hist;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) hist <= 2'b00;
    else hist <= {hist[0], s2};
  // Majority over three consecutive synchroniser outputs rejects single-clk glitches
  assign rx_bit = (s2 & hist[0]) | (s2 & hist[1]) | (hist[0] & hist[1]);
`else
  assign rx_bit = s2;
`endif
  assign sample     = rx_en && clk_cnt == SAMPLE_PHASE;
  assign sync_shift = {sync_sr[14:0], rx_bit};
  assign word       = {data_sr[30:0], rx_bit};
  assign busy       = state == RECV;
  always_comb begin
    state_n = state;
    sync_n  = sync_sr;
    data_n  = data_sr;
    cnt_n   = bit_cnt;
    cmd_n   = cmd_data;
    frame_n = frame_cnt;
    valid_n = 1'b0;
    if (!rx_en) begin
      state_n = HUNT;
      sync_n  = '0;
      cnt_n   = '0;
    end else if (sample && state == HUNT) begin
      state_n = sync_shift == SYNC_WORD ? RECV : HUNT;
      sync_n  = sync_shift == SYNC_WORD ? '0 : sync_shift;
      cnt_n   = '0;
    end else if (sample) begin
      data_n  = word;
      cnt_n   = bit_cnt + 5'd1;
      valid_n = bit_cnt == 5'd31;
      state_n = valid_n ? HUNT : RECV;
      sync_n  = '0;
      cmd_n   = valid_n ? word : cmd_data;
      frame_n = valid_n ? frame_cnt + 8'd1 : frame_cnt;
    end
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state     <= HUNT;
      sync_sr   <= '0;
      data_sr   <= '0;
      bit_cnt   <= '0;
      cmd_data  <= '0;
      cmd_valid <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_n;
      sync_sr   <= sync_n;
      data_sr   <= data_n;
      bit_cnt   <= cnt_n;
      cmd_data  <= cmd_n;
      cmd_valid <= valid_n;
      frame_cnt <= frame_n;
    end
endmodule
